// File: rtl/tdc_cfg_seq_pkg.sv
// Shared state type and sizing helper for the TDC configuration sequencer.
package tdc_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_DONE  = 2'd3
  } cfg_state_t;

  // Divider counter width for a given SCLK half-period.
  function automatic int div_cnt_w(input int clk_div);
    return $clog2(clk_div + 1);
  endfunction

endpackage

// File: rtl/tdc_cfg_seq_sclk_gen.sv
// SCLK divider: rise marks the first cycle SCLK is high; fall marks the cycle
// whose closing edge drops SCLK, so the caller can launch SDO on that same edge.
module tdc_sclk_gen
  import tdc_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = div_cnt_w(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = run && (cnt == CNT_TOP);
  assign fall = wrap && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
      rise <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      sclk <= 1'b0;
      rise <= 1'b0;
    end else begin
      rise <= wrap && !sclk;
      if (wrap) begin
        cnt  <= '0;
        sclk <= ~sclk;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tdc_cfg_seq.sv
// Serial loader for the TDC config chain: shift, latch, optional verify pass.
//   state    | meaning
//   ST_IDLE  | waiting for START
//   ST_SHIFT | clocking shadow out on SDO, capturing SDI
//   ST_LATCH | SLD high for 2*CLK_DIV cycles
//   ST_DONE  | one-cycle DONE pulse
module tdc_cfg_seq
  import tdc_cfg_pkg::*;
#(
  parameter int CFG_WIDTH = 64,
  parameter int CLK_DIV   = 4
) (
  input  logic                 CLK,
  input  logic                 RESETB,
  input  logic                 START,
  input  logic                 VERIFY,
  input  logic                 ABORT,
  input  logic [CFG_WIDTH-1:0] CFG_DATA,
  output logic                 SCLK,
  output logic                 SDO,
  input  logic                 SDI,
  output logic                 SLD,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 MISMATCH,
  output logic [CFG_WIDTH-1:0] RB_DATA
);

  localparam int IDX_W = $clog2(CFG_WIDTH);
  localparam int LAT_W = $clog2(2 * CLK_DIV);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(CFG_WIDTH - 1);
  localparam logic [LAT_W-1:0] LAT_TOP = LAT_W'(2 * CLK_DIV - 1);

  cfg_state_t           state;
  logic [CFG_WIDTH-1:0] shadow;
  logic [CFG_WIDTH-1:0] cap;
  logic [IDX_W-1:0]     bit_idx;
  logic [LAT_W-1:0]     lat_cnt;
  logic                 verify_q;
  logic                 pass_q;
  logic                 sclk_run;
  logic                 sclk_rise;
  logic                 sclk_fall;

  // Dropping run on ABORT clears SCLK on the same edge the FSM returns to idle.
  assign sclk_run = (state == ST_SHIFT) && !ABORT;

  tdc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk   (CLK),
    .rst_n (RESETB),
    .run   (sclk_run),
    .sclk  (SCLK),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state    <= ST_IDLE;
      shadow   <= '0;
      cap      <= '0;
      bit_idx  <= '0;
      lat_cnt  <= '0;
      verify_q <= 1'b0;
      pass_q   <= 1'b0;
      SDO      <= 1'b0;
      SLD      <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      MISMATCH <= 1'b0;
      RB_DATA  <= '0;
    end else begin
      DONE <= 1'b0;
      if (ABORT && (state != ST_IDLE)) begin
        state <= ST_IDLE;
        SDO   <= 1'b0;
        SLD   <= 1'b0;
        BUSY  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (START) begin
              shadow   <= CFG_DATA;
              verify_q <= VERIFY;
              pass_q   <= 1'b0;
              MISMATCH <= 1'b0;
              bit_idx  <= IDX_TOP;
              SDO      <= CFG_DATA[CFG_WIDTH-1];
              BUSY     <= 1'b1;
              state    <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (sclk_rise) cap <= {cap[CFG_WIDTH-2:0], SDI};
            if (sclk_fall) begin
              if (bit_idx == '0) begin
                SDO     <= 1'b0;
                SLD     <= 1'b1;
                lat_cnt <= LAT_TOP;
                state   <= ST_LATCH;
              end else begin
                bit_idx <= bit_idx - 1'b1;
                SDO     <= shadow[bit_idx - 1'b1];
              end
            end
          end
          ST_LATCH: begin
            if (lat_cnt == '0) begin
              SLD     <= 1'b0;
              RB_DATA <= cap;
              // Chain returns the pass-0 word, so pass 1 must read back the shadow.
              if (pass_q) MISMATCH <= (cap != shadow);
              if (verify_q && !pass_q) begin
                pass_q  <= 1'b1;
                bit_idx <= IDX_TOP;
                SDO     <= shadow[CFG_WIDTH-1];
                state   <= ST_SHIFT;
              end else begin
                BUSY  <= 1'b0;
                DONE  <= 1'b1;
                state <= ST_DONE;
              end
            end else begin
              lat_cnt <= lat_cnt - 1'b1;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdc_cfg_seq.sv
// Scoreboard bench for tdc_cfg_seq with a behavioural TDC chain model.
module tb_tdc_cfg_seq;

  localparam int W        = 8;
  localparam int CD       = 2;
  localparam int PASS_CYC = 2 * CD * (W + 1);
  localparam int BUDGET   = 400;

  logic         CLK      = 1'b0;
  logic         RESETB   = 1'b0;
  logic         START    = 1'b0;
  logic         VERIFY   = 1'b0;
  logic         ABORT    = 1'b0;
  logic [W-1:0] CFG_DATA = '0;
  logic         SCLK, SDO, SDI, SLD, BUSY, DONE, MISMATCH;
  logic [W-1:0] RB_DATA;

  typedef struct {
    int           done_cyc;
    logic [W-1:0] rb;
    logic         mm;
  } exp_t;

  exp_t exp_q[$];
  logic sdo_q[$];
  int   sld_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int act_start = -10;
  int act_done  = -10;
  int sld_len   = 0;

  logic [W-1:0] chain       = '0;
  logic [W-1:0] stuck_mask  = '0;
  logic [W-1:0] preload_val = '0;
  logic [W-1:0] held_rb     = '0;
  logic         preload_en  = 1'b0;
  logic         sclk_d      = 1'b0;
  logic         sld_prev    = 1'b0;

  tdc_cfg_seq #(.CFG_WIDTH(W), .CLK_DIV(CD)) dut (
    .CLK      (CLK),
    .RESETB   (RESETB),
    .START    (START),
    .VERIFY   (VERIFY),
    .ABORT    (ABORT),
    .CFG_DATA (CFG_DATA),
    .SCLK     (SCLK),
    .SDO      (SDO),
    .SDI      (SDI),
    .SLD      (SLD),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .MISMATCH (MISMATCH),
    .RB_DATA  (RB_DATA)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_msg(input string name, input string what);
    total++;
    bad++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // TDC chain: shifts on SCLK rise, SDI is its far end; stuck bits bite when latched.
  assign SDI = chain[W-1];
  always @(posedge CLK) begin
    sclk_d <= SCLK;
    if (preload_en)            chain <= preload_val;
    else if (SCLK && !sclk_d)  chain <= {chain[W-2:0], SDO};
    else if (SLD)              chain <= chain & ~stuck_mask;
  end

  always @(negedge CLK) begin
    if (!RESETB) begin
      sld_prev <= 1'b0;
      sld_len  <= 0;
    end else begin
      if (SCLK && !sclk_d) begin
        if (sdo_q.size() == 0) fail_msg("sdo_extra", "SCLK rise with no bit expected");
        else chk("sdo_bit", 64'(SDO), 64'(sdo_q.pop_front()));
      end
      chk("busy", 64'(BUSY), 64'(cyc > act_start && cyc < act_done));
      if (!BUSY && !SLD) chk("sdo_idle", 64'(SDO), 64'd0);
      if (SLD) begin
        chk("sclk_in_latch", 64'(SCLK), 64'd0);
        sld_len <= sld_len + 1;
      end else if (sld_prev) begin
        if (sld_q.size() == 0) fail_msg("sld_extra", "unexpected SLD pulse");
        else chk("sld_len", 64'(sld_len), 64'(sld_q.pop_front()));
        sld_len <= 0;
      end
      sld_prev <= SLD;
      if (DONE) begin
        if (exp_q.size() == 0) fail_msg("done_extra", "unexpected DONE pulse");
        else begin
          chk("done_cycle", 64'(cyc), 64'(exp_q[0].done_cyc));
          chk("rb_data", 64'(RB_DATA), 64'(exp_q[0].rb));
          chk("mismatch", 64'(MISMATCH), 64'(exp_q[0].mm));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (cyc < act_done + 2 && n < BUDGET) begin
      @(posedge CLK);
      n++;
    end
    if (n >= BUDGET) fail_msg("timeout", "transaction did not finish");
    #1;
    chk("done_missing", 64'(exp_q.size()), 64'd0);
    chk("sdo_bits_left", 64'(sdo_q.size()), 64'd0);
    chk("sld_pulses_left", 64'(sld_q.size()), 64'd0);
  endtask

  task automatic run_txn(input logic [W-1:0] data, input logic v, input logic [W-1:0] mask,
                         input int abort_at, input int extra_at);
    int           passes = v ? 2 : 1;
    int           s;
    logic [W-1:0] c;
    logic [W-1:0] dm;
    exp_t         e;
    @(posedge CLK); #1;
    s  = cyc;
    c  = chain;
    dm = data & ~mask;
    stuck_mask = mask;
    for (int p = 0; p < passes; p++) begin
      for (int i = W - 1; i >= 0; i--) sdo_q.push_back(data[i]);
      sld_q.push_back(2 * CD);
    end
    e.done_cyc = s + 1 + PASS_CYC * passes;
    e.rb       = v ? dm : c;
    e.mm       = v && (dm != data);
    act_start  = s;
    act_done   = e.done_cyc;
    if (abort_at < 0) begin
      exp_q.push_back(e);
      held_rb = e.rb;
    end
    START = 1'b1; CFG_DATA = data; VERIFY = v;
    for (int k = 1; k < PASS_CYC * passes; k++) begin
      @(posedge CLK); #1;
      START    = (k == extra_at);
      CFG_DATA = (k == extra_at) ? '0 : W'($urandom);
      VERIFY   = 1'($urandom);
      if (k == abort_at) begin
        ABORT = 1'b1;
        act_done = cyc + 1;
        @(posedge CLK); #1;
        ABORT = 1'b0;
        sdo_q.delete();
        sld_q.delete();
        @(negedge CLK);
        chk("abort_sclk", 64'(SCLK), 64'd0);
        chk("abort_sld", 64'(SLD), 64'd0);
        chk("abort_busy", 64'(BUSY), 64'd0);
        chk("abort_done", 64'(DONE), 64'd0);
        chk("abort_sdo", 64'(SDO), 64'd0);
        chk("abort_rb", 64'(RB_DATA), 64'(held_rb));
        chk("abort_mismatch", 64'(MISMATCH), 64'd0);
        break;
      end
    end
    START = 1'b0;
    wait_idle();
  endtask

  task automatic reset_mid_latch(input logic [W-1:0] data);
    int n = 0;
    @(posedge CLK); #1;
    stuck_mask = '0;
    act_start  = cyc;
    act_done   = cyc + 1 + PASS_CYC;
    for (int i = W - 1; i >= 0; i--) sdo_q.push_back(data[i]);
    START = 1'b1; CFG_DATA = data; VERIFY = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0;
    while (!SLD && n < BUDGET) begin
      @(negedge CLK);
      n++;
    end
    if (!SLD) fail_msg("reset_wait_sld", "SLD never rose");
    else begin
      #2;
      RESETB   = 1'b0;
      act_done = cyc;
      #1;
      chk("reset_sld", 64'(SLD), 64'd0);
      chk("reset_sclk", 64'(SCLK), 64'd0);
      chk("reset_busy", 64'(BUSY), 64'd0);
      chk("reset_sdo", 64'(SDO), 64'd0);
      chk("reset_done", 64'(DONE), 64'd0);
      chk("reset_rb", 64'(RB_DATA), 64'd0);
      chk("reset_mismatch", 64'(MISMATCH), 64'd0);
    end
    held_rb = '0;
    sdo_q.delete();
    sld_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RESETB = 1'b1;
  endtask

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] m;
    logic         v;
    int           ab;
    int           ex;
    RESETB      = 1'b0;
    preload_val = 8'h3C;
    preload_en  = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    preload_en = 1'b0;
    chk("rst_sclk", 64'(SCLK), 64'd0);
    chk("rst_sdo", 64'(SDO), 64'd0);
    chk("rst_sld", 64'(SLD), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_mismatch", 64'(MISMATCH), 64'd0);
    chk("rst_rb", 64'(RB_DATA), 64'd0);
    RESETB = 1'b1;

    run_txn(8'hA5, 1'b0, 8'h00, -1, -1);
    run_txn(8'h5A, 1'b1, 8'h00, -1, -1);
    run_txn(8'hFF, 1'b1, 8'h08, -1, -1);
    run_txn(8'hA5, 1'b0, 8'h00, -1, 10);
    run_txn(8'hC3, 1'b0, 8'h00, 12, -1);
    run_txn(8'h96, 1'b0, 8'h00, -1, -1);
    reset_mid_latch(8'h3C);
    run_txn(8'h71, 1'b1, 8'h00, -1, -1);

    for (int t = 0; t < 20; t++) begin
      d  = W'($urandom);
      v  = 1'($urandom);
      m  = ($urandom_range(0, 2) == 0) ? W'(1 << $urandom_range(0, W - 1)) : '0;
      ab = -1;
      ex = -1;
      if ($urandom_range(0, 4) == 0) ab = int'($urandom_range(1, 2 * CD * W));
      else if ($urandom_range(0, 3) == 0) ex = int'($urandom_range(1, PASS_CYC * (v ? 2 : 1) - 1));
      run_txn(d, v, m, ab, ex);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdc_cfg_seq.md
# tdc_cfg_seq

Configuration sequencer for the TDC shift-register interface. On a start request it serially shifts a `CFG_WIDTH`-bit configuration word into the TDC over SCLK/SDO while capturing the old contents from SDI, then pulses SLD to latch it. An optional verify pass re-shifts the same word and compares the readback. It sits between the firmware register block (bus clock domain) and the `tdc_top` SCLK/SDI/SDO/SLD pins, replacing software bit-banging.

## Interface
- `CFG_WIDTH`, default 64: configuration chain length in bits (≥ 2).
- `CLK_DIV`, default 4: SCLK half-period in CLK cycles (≥ 1).
- `CLK` in 1: single clock, all logic on the rising edge.
- `RESETB` in 1: asynchronous, active-low reset.
- `START` in 1: one-cycle request, honoured only in IDLE.
- `VERIFY` in 1: sampled with START; selects the second shift pass.
- `ABORT` in 1: cancels any operation in progress.
- `CFG_DATA` in CFG_WIDTH: word to load; captured into the shadow on START.
- `SCLK` out 1: serial clock, idles low.
- `SDO` out 1: serial data to the TDC chain, MSB first.
- `SDI` in 1: serial data from the TDC chain end.
- `SLD` out 1: latch strobe into the TDC config register.
- `BUSY` out 1: high from the cycle after an accepted START until return to IDLE.
- `DONE` out 1: one-cycle pulse on normal completion.
- `MISMATCH` out 1: verify result, held until the next accepted START.
- `RB_DATA` out CFG_WIDTH: SDI capture from the last completed pass.

## Operation
- States:
  - IDLE: START goes to SHIFT.
  - SHIFT: after CFG_WIDTH bits, goes to LATCH.
  - LATCH: after 2·CLK_DIV cycles, goes to SHIFT if VERIFY was latched and this is pass 0; otherwise goes to DONE.
  - DONE: lasts one cycle, then returns to IDLE.
- START accepted in IDLE:
  - Shadow ← CFG_DATA; VERIFY is latched.
  - Pass ← 0; MISMATCH ← 0.
- START outside IDLE: ignored.
- SHIFT:
  - Bit index runs CFG_WIDTH-1 down to 0.
  - SDO = shadow[index], stable for a full SCLK period and changing only on SCLK falling edges.
  - On each SCLK rising edge, SDI is shifted into the capture register at the LSB (left shift).
- LATCH: SCLK=0, SDO=0, SLD=1. At exit, RB_DATA ← capture register.
- Verify, pass 1: after the final rising edge, MISMATCH ← (capture ≠ shadow). The chain returns the pass-0 word, so equality proves the load.
- ABORT, any state except IDLE:
  - Next cycle: IDLE, SCLK=0, SLD=0, SDO=0, BUSY=0.
  - No DONE pulse; RB_DATA and MISMATCH unchanged.
  - ABORT has priority over a same-cycle START.
- DONE asserts simultaneously with BUSY falling.
- Reset values: SCLK=0, SDO=0, SLD=0, BUSY=0, DONE=0, MISMATCH=0, RB_DATA=0, state IDLE.

## Timing
- Cycle 0: START high in IDLE.
- Cycle 1:
  - State SHIFT, BUSY=1, SDO=CFG_DATA[CFG_WIDTH-1], SCLK=0.
  - The divider counter runs 0..CLK_DIV-1 per half-period.
- SCLK rising edge: cycle 1+CLK_DIV. The SDI value present in that cycle is captured.
- SCLK falling edge: cycle 1+2·CLK_DIV, with the next SDO bit in the same cycle.
- One pass lasts 2·CLK_DIV·CFG_WIDTH cycles of SHIFT plus 2·CLK_DIV cycles of LATCH.
- DONE position:
  - Non-verify: DONE in cycle 1 + 2·CLK_DIV·(CFG_WIDTH+1).
  - Verify: DONE in cycle 1 + 4·CLK_DIV·(CFG_WIDTH+1).
- All outputs are registered; no combinational path from input to output.
- SDI is used directly. The TDC is clocked from the same CLK, so no synchroniser is required.
- Reset asserted mid-operation: outputs take their reset values immediately (asynchronous); SLD never glitches high.

## Structure
- Package `tdc_cfg_pkg`:
  - State enum `cfg_state_t` {IDLE, SHIFT, LATCH, DONE}.
  - Localparam for the divider counter width, $clog2(CLK_DIV+1).
- Sub-module `tdc_sclk_gen`:
  - Divider with `run` input.
  - Outputs SCLK plus one-cycle `rise`/`fall` strobes.
  - Cleared to SCLK=0 when `run`=0.
- Top FSM, shadow register, capture register and bit counter live in `tdc_cfg_seq`.

## Test plan
All scenarios use CFG_WIDTH=8, CLK_DIV=2.
- **Basic load:** CFG_DATA=0xA5, VERIFY=0, SDI tied to a model shift register preloaded with 0x3C.
  - SDO sequence 1,0,1,0,0,1,0,1.
  - SLD high for 4 cycles.
  - RB_DATA=0x3C.
  - DONE at cycle 37.
- **Verify pass:** CFG_DATA=0x5A, VERIFY=1, ideal chain model.
  - Two 32-cycle shift passes.
  - RB_DATA=0x5A, MISMATCH=0.
  - DONE at cycle 73.
- **Verify fail:** chain model with bit 3 stuck at 0, CFG_DATA=0xFF, VERIFY=1.
  - MISMATCH=1, RB_DATA=0xF7.
- **START while BUSY:** second START at cycle 10 with CFG_DATA=0x00.
  - Ignored; SDO stream still 0xA5; exactly one DONE.
- **ABORT mid-shift:** ABORT at cycle 12.
  - Next cycle SCLK=0, SLD=0, BUSY=0, no DONE.
  - Subsequent START runs normally.
- **Reset mid-LATCH:** RESETB low while SLD=1.
  - SLD, SCLK, BUSY go to 0 without waiting for a clock edge.
  - RB_DATA=0.
